// File: rtl/z80_alu16_pkg.sv
// Shared types and flag positions for the serial 16-bit Z80 ALU.
// Flags 5 and 3 follow the result when Z80_UNDOC_FLAGS_EN is defined, else pass f_in through.
`ifndef FLAG_C_NUM
`define FLAG_C_NUM 0
`endif
`ifndef FLAG_N_NUM
`define FLAG_N_NUM 1
`endif
`ifndef FLAG_PV_NUM
`define FLAG_PV_NUM 2
`endif
`ifndef FLAG_3_NUM
`define FLAG_3_NUM 3
`endif
`ifndef FLAG_H_NUM
`define FLAG_H_NUM 4
`endif
`ifndef FLAG_5_NUM
`define FLAG_5_NUM 5
`endif
`ifndef FLAG_Z_NUM
`define FLAG_Z_NUM 6
`endif
`ifndef FLAG_S_NUM
`define FLAG_S_NUM 7
`endif

package z80_alu16_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SBC = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // The slice adder must tile the 16-bit word exactly.
  function automatic bit slice_w_legal(int w);
    return (w >= 1) && (w <= DATA_W) && ((DATA_W % w) == 0);
  endfunction

endpackage

// File: rtl/z80_alu_slice.sv
// Combinational W-bit adder slice with carry in and carry out.
module z80_alu_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total;

  assign total       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign {cout, sum} = total;

endmodule

// File: rtl/z80_alu16_serial.sv
// Multi-cycle 16-bit ADD/ADC/SBC for Z80 register pairs, iterating a SLICE_W-bit adder LSB first.
// Build option: Z80_UNDOC_FLAGS_EN makes flags 5 and 3 copy result bits 13 and 11.
module z80_alu16_serial
  import z80_alu16_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [7:0]  f_in,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [15:0] result,
  output logic [7:0]  f_out,
  output logic        busy
);

  localparam int N_SLICES = DATA_W / SLICE_W;
  localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SLICES - 1);

  if (!slice_w_legal(SLICE_W)) begin : g_bad_slice_w
    $error("z80_alu16_serial: SLICE_W must be 1, 2, 4, 8 or 16");
  end

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [15:0]       a_q, a_d;
  logic [15:0]       bb_q, bb_d;
  logic [7:0]        f_in_q, f_in_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       result_q, result_d;
  logic [7:0]        f_out_q, f_out_d;

  int                slice_base;
  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic              slice_cout;
  logic [15:0]       r_next;
  logic [7:0]        flags_next;
  logic              is_sbc;
  logic              half;

  always_comb begin
    slice_base = int'(cnt_q) * SLICE_W;
    slice_a    = a_q[slice_base +: SLICE_W];
    slice_b    = bb_q[slice_base +: SLICE_W];
    r_next     = result_q;
    r_next[slice_base +: SLICE_W] = slice_sum;
  end

  z80_alu_slice #(.W(SLICE_W)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Only meaningful on the last slice, where r_next is the complete result and
  // slice_cout is the carry out of bit 15.
  always_comb begin
    is_sbc     = (op_q == OP_SBC);
    half       = a_q[12] ^ bb_q[12] ^ r_next[12];
    flags_next = f_in_q;
    flags_next[`FLAG_C_NUM] = slice_cout ^ is_sbc;
    flags_next[`FLAG_H_NUM] = half ^ is_sbc;
    flags_next[`FLAG_N_NUM] = is_sbc;
    if (op_q != OP_ADD) begin
      flags_next[`FLAG_S_NUM]  = r_next[15];
      flags_next[`FLAG_Z_NUM]  = (r_next == 16'h0000);
      flags_next[`FLAG_PV_NUM] = (a_q[15] == bb_q[15]) && (r_next[15] != a_q[15]);
    end
`ifdef Z80_UNDOC_FLAGS_EN
    flags_next[`FLAG_5_NUM] = r_next[13];
    flags_next[`FLAG_3_NUM] = r_next[11];
`endif
  end

  // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    bb_d     = bb_q;
    f_in_d   = f_in_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    f_out_d  = f_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          op_d   = (op_e'(op) == OP_RSV) ? OP_ADD : op_e'(op);
          a_d    = a;
          bb_d   = (op_e'(op) == OP_SBC) ? ~b : b;
          f_in_d = f_in;
          case (op_e'(op))
            OP_ADC:  carry_d = f_in[`FLAG_C_NUM];
            OP_SBC:  carry_d = ~f_in[`FLAG_C_NUM];
            default: carry_d = 1'b0;
          endcase
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d = r_next;
        carry_d  = slice_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          f_out_d = flags_next;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so result/f_out read as zero
  // straight after reset rather than holding stale operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      bb_q     <= '0;
      f_in_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      f_out_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      bb_q     <= bb_d;
      f_in_q   <= f_in_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      f_out_q  <= f_out_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign done_valid  = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign result      = result_q;
  assign f_out       = f_out_q;

endmodule

// File: tb/tb_z80_alu16_serial.sv
// Scoreboard bench for z80_alu16_serial: three instances (SLICE_W 4, 1, 16) share operands.
module tb_z80_alu16_serial;

  localparam bit UNDOC =
`ifdef Z80_UNDOC_FLAGS_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    int          inst;
    logic [15:0] r;
    logic [7:0]  f;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  sv, srdy, dv, dr, bsy;
  logic [1:0]  op_i;
  logic [15:0] a_i, b_i;
  logic [7:0]  fi_i;
  logic [15:0] res [3];
  logic [7:0]  fo [3];

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   rise_cyc [3];
  logic [2:0] dv_prev = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SW = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    z80_alu16_serial #(.SLICE_W(SW)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_valid (sv[g]),
      .start_ready (srdy[g]),
      .op          (op_i),
      .a           (a_i),
      .b           (b_i),
      .f_in        (fi_i),
      .done_valid  (dv[g]),
      .done_ready  (dr[g]),
      .result      (res[g]),
      .f_out       (fo[g]),
      .busy        (bsy[g])
    );
  end

  function automatic int lat_of(int inst);
    return (inst == 0) ? 4 : (inst == 1) ? 16 : 1;
  endfunction

  // Adds flags 5/3 to a hand-computed base flag byte (base has those bits clear).
  function automatic logic [7:0] xf(logic [7:0] base, logic [7:0] fi, logic [15:0] r);
    logic [7:0] from_r;
    logic [7:0] from_f;
    from_r = {2'b00, r[13], 1'b0, r[11], 3'b000};
    from_f = fi & 8'h28;
    return base | (UNDOC ? from_r : from_f);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(int inst, logic [1:0] o, logic [15:0] av, logic [15:0] bv,
                       logic [7:0] fv, logic [15:0] er, logic [7:0] ef);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    op_i = o; a_i = av; b_i = bv; fi_i = fv;
    sv[inst] = 1'b1;
    while (!srdy[inst] && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_checks++;
      n_err++;
      $display("FAIL issue_timeout inst=%0d: start_ready stayed 0", inst);
      sv[inst] = 1'b0;
    end else begin
      e.inst = inst; e.r = er; e.f = ef; e.lat = lat_of(inst); e.acc = cyc + 1;
      sb_q.push_back(e);
      @(posedge clk);
      #1 sv[inst] = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("sb_drain", sb_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: a result is taken when done_valid && done_ready at the sampling edge.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (dv[i] && !dv_prev[i]) rise_cyc[i] = cyc;
      dv_prev[i] = dv[i];
      if (dv[i] && dr[i]) begin
        int j;
        j = -1;
        foreach (sb_q[k]) if (j < 0 && sb_q[k].inst == i) j = k;
        if (j < 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_done inst=%0d: result 0x%0h with nothing expected", i, res[i]);
        end else begin
          exp_t e;
          e = sb_q[j];
          sb_q.delete(j);
          check($sformatf("result_i%0d", i), res[i], e.r);
          check($sformatf("f_out_i%0d", i), fo[i], e.f);
          check($sformatf("latency_i%0d", i), rise_cyc[i] - e.acc, e.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n = 1'b0;
    sv = '0; dr = '1;
    op_i = 2'b00; a_i = '0; b_i = '0; fi_i = '0;
    #3;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_start_ready_i%0d", i), srdy[i], 1);
      check($sformatf("rst_done_valid_i%0d", i), dv[i], 0);
      check($sformatf("rst_busy_i%0d", i), bsy[i], 0);
      check($sformatf("rst_result_i%0d", i), res[i], 0);
      check($sformatf("rst_f_out_i%0d", i), fo[i], 0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors on the SLICE_W=4 instance, back to back.
    issue(0, 2'b00, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, xf(8'hD4, 8'hC4, 16'h1000));
    issue(0, 2'b10, 16'h0000, 16'h0001, 8'h00, 16'hFFFF, xf(8'h93, 8'h00, 16'hFFFF));
    issue(0, 2'b10, 16'h1234, 16'h1233, 8'h29, 16'h0000, xf(8'h42, 8'h29, 16'h0000));
    issue(0, 2'b11, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, xf(8'h11, 8'h00, 16'h0000));
    issue(0, 2'b01, 16'hFFFF, 16'hFFFF, 8'h01, 16'hFFFF, xf(8'h91, 8'h01, 16'hFFFF));
    issue(0, 2'b10, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, xf(8'h16, 8'h00, 16'h7FFF));
    drain();

    // Backpressure with ADC 0x7FFF + 0 + 1; stray start_valid while in DONE is ignored.
    @(posedge clk);
    #1 dr[0] = 1'b0;
    issue(0, 2'b01, 16'h7FFF, 16'h0000, 8'h01, 16'h8000, xf(8'h94, 8'h01, 16'h8000));
    cnt = 0;
    while (!dv[0] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("bp_reach_done", dv[0], 1);
    sv[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) sv[0] = 1'b0;
      check("bp_done_valid", dv[0], 1);
      check("bp_start_ready", srdy[0], 0);
      check("bp_busy", bsy[0], 1);
      check("bp_result", res[0], 16'h8000);
      check("bp_f_out", fo[0], xf(8'h94, 8'h01, 16'h8000));
    end
    sv[0] = 1'b0;
    @(posedge clk);
    #1 dr[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_start_ready_after", srdy[0], 1);
    check("bp_done_valid_after", dv[0], 0);
    check("bp_result_held_idle", res[0], 16'h8000);

    // Same ADD on SLICE_W=1 and SLICE_W=16.
    issue(1, 2'b00, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, xf(8'hD4, 8'hC4, 16'h1000));
    issue(2, 2'b00, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, xf(8'hD4, 8'hC4, 16'h1000));
    drain();

    // Reset in the middle of RUN drops the operation.
    @(negedge clk);
    op_i = 2'b00; a_i = 16'h1111; b_i = 16'h2222; fi_i = 8'h00;
    sv[0] = 1'b1;
    @(posedge clk);
    #1 sv[0] = 1'b0;
    @(posedge clk);
    #1 check("busy_mid_run", bsy[0], 1);
    reset_n = 1'b0;
    #1;
    check("rrst_start_ready", srdy[0], 1);
    check("rrst_done_valid", dv[0], 0);
    check("rrst_busy", bsy[0], 0);
    check("rrst_result", res[0], 0);
    check("rrst_f_out", fo[0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dv[0]) cnt++;
    end
    check("no_done_after_reset", cnt, 0);
    check("sb_empty_end", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
